warm_up_ctrl: RTL
=================

WARM_UP_CTRL -- requirements
Module: warm_up_ctrl

Interface
REQ-001 SHALL provide parameter TEMP_W, default 8, width of the temperature inputs.
REQ-002 SHALL provide parameter HYST, default 2, hysteresis band below target, in temperature LSBs.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 16, number of consecutive in-band cycles required for completion (>=1).
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 1024, maximum cycles allowed in HEAT plus HOLD (>HOLD_CYCLES).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port warm_en, input, 1, request warm-up; level, held for the whole cycle.
REQ-008 SHALL have port target_temp, input, TEMP_W, unsigned setpoint.
REQ-009 SHALL have port cur_temp, input, TEMP_W, unsigned measured water temperature.
REQ-010 SHALL have port heater_on, output, 1, heater drive, registered.
REQ-011 SHALL have port warm_busy, output, 1, high in HEAT or HOLD, registered.
REQ-012 SHALL have port warm_done, output, 1, level, high in DONE, registered.
REQ-013 SHALL have port warm_err, output, 1, level, high in ERR (timeout), registered.
REQ-014 SHALL have port warm_state, output, 3, current FSM state encoding, for debug.

Function
REQ-015 SHALL implement states IDLE, HEAT, HOLD, DONE, ERR.
REQ-016 SHALL compute low_th = target_temp - HYST, saturating at 0, in TEMP_W bits.
REQ-017 SHALL, in IDLE with warm_en=1, go to HEAT and clear the timeout and hold counters.
REQ-018 SHALL, in HEAT, go to HOLD with hold counter cleared when cur_temp >= target_temp.
REQ-019 SHALL, in HOLD, go back to HEAT when cur_temp < low_th; otherwise increment the hold counter.
REQ-020 SHALL, in HOLD, go to DONE when the hold counter equals HOLD_CYCLES-1 and cur_temp >= low_th.
REQ-021 SHALL increment the timeout counter every cycle in HEAT or HOLD, and go to ERR when it equals TIMEOUT_CYCLES-1.
REQ-022 SHALL apply transition priority: warm_en=0, then DONE completion, then timeout, then temperature transitions.
REQ-023 SHALL return from HEAT, HOLD, DONE or ERR to IDLE on the next edge when warm_en=0 (abort/release).
REQ-024 SHALL hold DONE and ERR while warm_en=1; no automatic restart.
REQ-025 SHALL drive heater_on=1 in HEAT and 0 in IDLE, DONE and ERR.
REQ-026 SHALL, in HOLD, drive heater_on=0 when cur_temp >= target_temp, 1 when cur_temp < low_th, else keep its previous value.
REQ-027 SHALL register all outputs so each reflects the state entered at the same edge: one-cycle latency from a sampled input.
REQ-028 SHALL not let counters wrap; each saturates at its terminal value.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, enter IDLE, clear both counters and drive heater_on, warm_busy, warm_done and warm_err to 0 and warm_state to the IDLE encoding.
REQ-030 SHALL treat reset mid-operation identically; no heater pulse after the reset edge.

Structure
REQ-031 SHALL take state encodings (IDLE=0, HEAT=1, HOLD=2, DONE=3, ERR=4) and parameter defaults from shared package warm_up_pkg.
REQ-032 SHALL implement both counters by instantiating one sub-module, warm_up_timer: a clearable, enabled, saturating up-counter with a terminal-count flag.

Verification (bench params: HYST=2, HOLD_CYCLES=4, TIMEOUT_CYCLES=20, target=50)
REQ-033 SHALL check nominal operation: warm_en=1, cur_temp ramps 40->50 over 5 cycles, then holds at 50. Required: heater_on=1 one cycle after warm_en; HOLD on reaching 50; warm_done=1 after 4 HOLD cycles; heater_on=0.
REQ-034 SHALL check hysteresis: in HOLD, cur_temp 49 keeps heater_on at its previous value and the hold count continues; cur_temp 47 (<48) returns to HEAT with heater_on=1.
REQ-035 SHALL check timeout: cur_temp stuck at 30. Required: warm_err=1 and heater_on=0 exactly 20 cycles after HEAT entry; warm_err stays high until warm_en=0.
REQ-036 SHALL check abort: warm_en dropped in HEAT. Required: IDLE next edge, all outputs 0.
REQ-037 SHALL check reset: rst_n=0 for 1 cycle during HOLD. Required: IDLE and all outputs 0 at that edge; with warm_en=1, HEAT on the edge after rst_n returns high.
REQ-038 SHALL check saturation: target_temp=1, cur_temp=0. Required: low_th=0 and no return from HOLD to HEAT.

Source files
------------

// File: rtl/warm_up_pkg.sv
// Shared state encodings and parameter defaults for the water warm-up controller.
package warm_up_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAT = 3'd1,
        ST_HOLD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } warm_state_e;

    localparam int DEF_TEMP_W         = 8;
    localparam int DEF_HYST           = 2;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // HEAT and HOLD together form the "warm-up in progress" window.
    function automatic logic is_active(input warm_state_e s);
        return (s == ST_HEAT) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/warm_up_timer.sv
// Clearable, enabled up-counter that saturates at TERMINAL and flags it.
module warm_up_timer #(
    parameter int W        = 4,
    parameter int TERMINAL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

    logic [W-1:0] count;

    assign tc = (count == TC_VAL);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/warm_up_ctrl.sv
// Heater warm-up FSM: heat to target, hold within a hysteresis band, then report done or timeout.
module warm_up_ctrl
    import warm_up_pkg::*;
#(
    parameter int TEMP_W         = DEF_TEMP_W,
    parameter int HYST           = DEF_HYST,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              warm_en,
    input  logic [TEMP_W-1:0] target_temp,
    input  logic [TEMP_W-1:0] cur_temp,
    output logic              heater_on,
    output logic              warm_busy,
    output logic              warm_done,
    output logic              warm_err,
    output logic [2:0]        warm_state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TEMP_W-1:0] HYST_V = TEMP_W'(HYST);

    warm_state_e       state;
    warm_state_e       nxt_state;
    logic              nxt_heater;
    logic [TEMP_W-1:0] low_th;
    logic              hold_tc;
    logic              to_tc;
    logic              at_target;
    logic              below_band;

    // Lower edge of the band clamps at zero instead of wrapping for small setpoints.
    assign low_th     = (target_temp > HYST_V) ? target_temp - HYST_V : '0;
    assign at_target  = (cur_temp >= target_temp);
    assign below_band = (cur_temp < low_th);

    warm_up_timer #(.W(HOLD_W), .TERMINAL(HOLD_CYCLES - 1)) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_HOLD),
        .en    (state == ST_HOLD),
        .tc    (hold_tc)
    );

    warm_up_timer #(.W(TO_W), .TERMINAL(TIMEOUT_CYCLES - 1)) u_timeout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!is_active(state)),
        .en    (is_active(state)),
        .tc    (to_tc)
    );

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        nxt_state  = state;
        nxt_heater = heater_on;
        case (state)
            ST_IDLE: if (warm_en) nxt_state = ST_HEAT;
            ST_HEAT: begin
                if (!warm_en)       nxt_state = ST_IDLE;
                else if (to_tc)     nxt_state = ST_ERR;
                else if (at_target) nxt_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!warm_en)                     nxt_state = ST_IDLE;
                else if (hold_tc && !below_band)  nxt_state = ST_DONE;
                else if (to_tc)                   nxt_state = ST_ERR;
                else if (below_band)              nxt_state = ST_HEAT;
            end
            ST_DONE, ST_ERR: if (!warm_en) nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase

        // Heater follows the state being entered so it changes on the same edge.
        case (nxt_state)
            ST_HEAT: nxt_heater = 1'b1;
            ST_HOLD: begin
                if (at_target)       nxt_heater = 1'b0;
                else if (below_band) nxt_heater = 1'b1;
            end
            default: nxt_heater = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            heater_on <= 1'b0;
            warm_busy <= 1'b0;
            warm_done <= 1'b0;
            warm_err  <= 1'b0;
        end else begin
            state     <= nxt_state;
            heater_on <= nxt_heater;
            warm_busy <= is_active(nxt_state);
            warm_done <= (nxt_state == ST_DONE);
            warm_err  <= (nxt_state == ST_ERR);
        end
    end

    assign warm_state = state;

endmodule
